lc3_operate_sequencer: RTL and testbench
========================================

# lc3_operate_sequencer

Issue/control sequencer for LC-3 operate instructions (ADD, AND, NOT) that drives the combinational ALU from the instruction side. Accepts one 16-bit instruction per valid/ready handshake and decodes it. Reads an internal 8x16 register file, presents operands, the IR immediate field and the ALU function to the ALU, then captures the ALU result. Writes the result back, updates NZP condition codes and flags unsupported opcodes.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- instValid  in  1  instruction offered
- instReady  out  1  sequencer can accept an instruction
- instr  in  16  LC-3 instruction word
- regWe  in  1  register preload strobe (honoured in IDLE only)
- regAddr  in  3  preload register index
- regWData  in  16  preload data
- regRdAddr  in  3  debug read index
- regRdData  out  16  combinational read of register[regRdAddr]
- aluRa  out  16  ALU operand A
- aluRb  out  16  ALU operand B (register SR2)
- aluIR  out  6  instr[5:0] to ALU immediate mux
- aluControl  out  2  00 pass, 01 add, 10 and, 11 not
- aluOut  in  16  ALU result (combinational from above)
- wbValid  out  1  one-cycle writeback pulse
- wbReg  out  3  destination register of writeback
- wbData  out  16  written value
- nzp  out  3  condition codes {N,Z,P}
- illegal  out  1  one-cycle pulse on unsupported opcode

## Operation
- Decode: opcode = instr[15:12], DR = [11:9], SR1 = [8:6], SR2 = [2:0].
  - 0001 maps to aluControl 01.
  - 0101 maps to 10.
  - 1001 maps to 11; instr[5:0] is not checked.
  - All other opcodes are illegal.
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE -> DECODE on instValid && instReady; instr is latched.
  - DECODE: a legal opcode goes to EXEC. An illegal opcode pulses illegal and returns to IDLE, with no writeback and no NZP change.
  - EXEC -> WB. aluOut is captured into the result register at the end of EXEC.
  - WB -> IDLE. Register[DR] is written and NZP is updated at the end of WB.
- Operands are registered in DECODE: aluRa = reg[SR1], aluRb = reg[SR2], aluIR = instr[5:0]. They hold through EXEC.
- Register-file reads in DECODE see pre-write values. DR == SR1/SR2 needs no special handling, because writeback completes before the next accept.
- aluControl equals the decoded function during EXEC only; it is 00 in all other states.
- NZP from the written 16-bit value:
  - bit15 set gives 100.
  - zero gives 010.
  - otherwise 001.
- instReady = (state == IDLE) && !regWe. When regWe and instValid are both high in IDLE, the preload wins and the instruction is not accepted.
- regWe outside IDLE is ignored.

## Timing
- Accept edge T.
  - DECODE occupies cycle T+1.
  - EXEC occupies T+2, with aluControl valid.
  - WB occupies T+3: wbValid = 1, wbReg and wbData valid.
  - instReady = 1 again at T+4.
- Throughput is one instruction per 4 cycles.
- Illegal opcode: illegal = 1 in T+1; instReady = 1 at T+2.
- Reset values:
  - FSM state IDLE.
  - All registers 0.
  - aluRa, aluRb 0; aluIR 0; aluControl 00.
  - wbValid 0, wbReg 0, wbData 0, illegal 0.
  - nzp 010.
  - instReady 1 once reset_n is high, unless regWe is asserted.
- Reset asserted mid-operation: the FSM goes immediately to IDLE. There is no wbValid, and register contents and nzp take their reset values.
- wbData and wbReg hold their last values after WB; only wbValid pulses.

## Test plan
- Preload R1=5, R2=3; issue ADD 0x1042 -> aluControl=01 at T+2; wbValid at T+3 with wbReg=0, wbData=0x0008; nzp=001; instReady high at T+4.
- Issue 0x167A (ADD R3,R1,#-6) with R1=5 -> aluIR=0x3A; wbData=0xFFFF, wbReg=3, nzp=100.
- Issue 0x5860 (AND R4,R1,#0) -> aluControl=10, wbData=0x0000, nzp=010; regRdAddr=4 reads 0.
- Issue 0x9A7F (NOT R5,R1) with R1=5 -> aluControl=11, wbData=0xFFFA, nzp=100.
- Issue 0x0000 (BR) -> illegal pulse at T+1, no wbValid, all registers and nzp unchanged, instReady=1 at T+2.
- Drop reset_n during EXEC of an ADD -> no wbValid; all outputs at reset values, nzp=010, R1 reads 0. A following ADD 0x1042 yields wbData=0, nzp=010.
- Drive regWe and instValid together in IDLE -> instReady=0 that cycle, preload applied, instruction accepted the next cycle.

Source files
------------

// File: rtl/lc3_operate_sequencer.sv
// lc3_operate_sequencer
//   Issue/control sequencer for the LC-3 operate group (ADD, AND, NOT).
//   It accepts one instruction per valid/ready handshake. The instruction then
//   walks IDLE -> DECODE -> EXEC -> WB. In DECODE the operands are read from an
//   internal 8x16 register file and presented to an external combinational
//   ALU. The ALU result is captured at the end of EXEC and written back in WB,
//   where the NZP condition codes are also updated.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   instValid / instReady  instruction handshake
//   instr[15:0]            instruction word, latched on accept
//   regWe/regAddr/regWData register preload, honoured in IDLE only
//   regRdAddr/regRdData    combinational debug read port
//   aluRa/aluRb/aluIR      ALU operands, registered in DECODE
//   aluControl             ALU function: 00 pass, 01 add, 10 and, 11 not
//   aluOut                 ALU result, combinational from the ALU inputs
//   wbValid/wbReg/wbData   writeback pulse, with reg and data that hold after WB
//   nzp                    condition codes {N,Z,P}
//   illegal                one-cycle pulse for an unsupported opcode
module lc3_operate_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instValid,
  output logic        instReady,
  input  logic [15:0] instr,
  input  logic        regWe,
  input  logic [2:0]  regAddr,
  input  logic [15:0] regWData,
  input  logic [2:0]  regRdAddr,
  output logic [15:0] regRdData,
  output logic [15:0] aluRa,
  output logic [15:0] aluRb,
  output logic [5:0]  aluIR,
  output logic [1:0]  aluControl,
  input  logic [15:0] aluOut,
  output logic        wbValid,
  output logic [2:0]  wbReg,
  output logic [15:0] wbData,
  output logic [2:0]  nzp,
  output logic        illegal
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] WB     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] regs_q [8];
  logic [15:0] ra_q, rb_q;
  logic [5:0]  imm_q;
  logic [15:0] result_q;
  logic [2:0]  wbreg_q;
  logic [2:0]  nzp_q;

  logic        legal;
  logic [1:0]  func;

  function automatic logic [2:0] calc_nzp(input logic [15:0] v);
    if (v[15])          return 3'b100;
    else if (v == 16'h0) return 3'b010;
    else                return 3'b001;
  endfunction

  // Decode from the latched instruction. NOT does not check instr[5:0].
  always_comb begin
    legal = 1'b1;
    func  = 2'b00;
    case (ir_q[15:12])
      4'b0001: func = 2'b01;
      4'b0101: func = 2'b10;
      4'b1001: func = 2'b11;
      default: legal = 1'b0;
    endcase
  end

  // The preload strobe blocks acceptance, so both never land in the same edge.
  assign instReady = (state_q == IDLE) && !regWe;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instValid && instReady) state_d = DECODE;
      DECODE:  state_d = legal ? EXEC : IDLE;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      imm_q    <= '0;
      result_q <= '0;
      wbreg_q  <= '0;
      nzp_q    <= 3'b010;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (regWe)
            regs_q[regAddr] <= regWData;
          else if (instValid)
            ir_q <= instr;
        end
        // Operand read sees pre-write values. The previous writeback has
        // already completed before this instruction could be accepted.
        DECODE: begin
          ra_q  <= regs_q[ir_q[8:6]];
          rb_q  <= regs_q[ir_q[2:0]];
          imm_q <= ir_q[5:0];
        end
        EXEC: begin
          result_q <= aluOut;
          wbreg_q  <= ir_q[11:9];
        end
        WB: begin
          regs_q[wbreg_q] <= result_q;
          nzp_q           <= calc_nzp(result_q);
        end
        default: ;
      endcase
    end
  end

  assign regRdData  = regs_q[regRdAddr];
  assign aluRa      = ra_q;
  assign aluRb      = rb_q;
  assign aluIR      = imm_q;
  assign aluControl = (state_q == EXEC) ? func : 2'b00;
  assign wbValid    = (state_q == WB);
  assign wbReg      = wbreg_q;
  assign wbData     = result_q;
  assign nzp        = nzp_q;
  assign illegal    = (state_q == DECODE) && !legal;

endmodule

// File: tb/tb_lc3_operate_sequencer.sv
module tb_lc3_operate_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instValid;
  logic        instReady;
  logic [15:0] instr;
  logic        regWe;
  logic [2:0]  regAddr;
  logic [15:0] regWData;
  logic [2:0]  regRdAddr;
  logic [15:0] regRdData;
  logic [15:0] aluRa, aluRb;
  logic [5:0]  aluIR;
  logic [1:0]  aluControl;
  logic [15:0] aluOut;
  logic        wbValid;
  logic [2:0]  wbReg;
  logic [15:0] wbData;
  logic [2:0]  nzp;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural LC-3 ALU: the immediate mux is steered by aluIR[5].
  logic [15:0] opB;
  assign opB = aluIR[5] ? {{11{aluIR[4]}}, aluIR[4:0]} : aluRb;
  always_comb begin
    case (aluControl)
      2'b01:   aluOut = aluRa + opB;
      2'b10:   aluOut = aluRa & opB;
      2'b11:   aluOut = ~aluRa;
      default: aluOut = aluRa;
    endcase
  end

  lc3_operate_sequencer dut (
    .clk(clk), .reset_n(reset_n), .instValid(instValid), .instReady(instReady),
    .instr(instr), .regWe(regWe), .regAddr(regAddr), .regWData(regWData),
    .regRdAddr(regRdAddr), .regRdData(regRdData), .aluRa(aluRa), .aluRb(aluRb),
    .aluIR(aluIR), .aluControl(aluControl), .aluOut(aluOut), .wbValid(wbValid),
    .wbReg(wbReg), .wbData(wbData), .nzp(nzp), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    regWe = 1'b1; regAddr = a; regWData = d;
    tick();
    regWe = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input string tag, input logic [15:0] exp);
    regRdAddr = a;
    #1;
    chk(tag, regRdData, exp);
  endtask

  // Offers an instruction while idle. On return the DUT is in cycle T+1.
  task automatic offer(input logic [15:0] w);
    instValid = 1'b1; instr = w;
    tick();
    instValid = 1'b0;
  endtask

  // Full legal instruction: checks EXEC (T+2), WB (T+3) and ready again (T+4).
  task automatic run_op(input string nm, input logic [15:0] w, input logic [1:0] ctl,
                        input logic [5:0] ir, input logic [2:0] dr,
                        input logic [15:0] res, input logic [2:0] cc);
    offer(w);
    chk({nm, "_decode_notready"}, {15'd0, instReady}, 16'd0);
    tick();
    chk({nm, "_exec_ctl"}, {14'd0, aluControl}, {14'd0, ctl});
    chk({nm, "_exec_ir"}, {10'd0, aluIR}, {10'd0, ir});
    tick();
    chk({nm, "_wb_valid"}, {15'd0, wbValid}, 16'd1);
    chk({nm, "_wb_reg"}, {13'd0, wbReg}, {13'd0, dr});
    chk({nm, "_wb_data"}, wbData, res);
    chk({nm, "_wb_ctl_idle"}, {14'd0, aluControl}, 16'd0);
    tick();
    chk({nm, "_ready_t4"}, {15'd0, instReady}, 16'd1);
    chk({nm, "_wbvalid_drop"}, {15'd0, wbValid}, 16'd0);
    chk({nm, "_nzp"}, {13'd0, nzp}, {13'd0, cc});
    rd(dr, {nm, "_rf_dr"}, res);
  endtask

  initial begin
    reset_n = 1'b0; instValid = 1'b0; instr = '0; regWe = 1'b0;
    regAddr = '0; regWData = '0; regRdAddr = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst_nzp", {13'd0, nzp}, 16'h0002);
    chk("rst_ready", {15'd0, instReady}, 16'd1);
    chk("rst_wbvalid", {15'd0, wbValid}, 16'd0);
    chk("rst_ctl", {14'd0, aluControl}, 16'd0);
    chk("rst_ra", aluRa, 16'd0);
    chk("rst_wbdata", wbData, 16'd0);
    chk("rst_illegal", {15'd0, illegal}, 16'd0);

    preload(3'd1, 16'd5);
    preload(3'd2, 16'd3);
    preload(3'd4, 16'h1234);
    rd(3'd1, "pre_r1", 16'd5);
    rd(3'd4, "pre_r4", 16'h1234);

    run_op("add_rr",  16'h1042, 2'b01, 6'h02, 3'd0, 16'h0008, 3'b001);
    run_op("add_imm", 16'h167A, 2'b01, 6'h3A, 3'd3, 16'hFFFF, 3'b100);
    run_op("and_z",   16'h5860, 2'b10, 6'h20, 3'd4, 16'h0000, 3'b010);
    run_op("not",     16'h9A7F, 2'b11, 6'h3F, 3'd5, 16'hFFFA, 3'b100);

    // Illegal opcode: pulse in T+1, back to IDLE at T+2, nothing written.
    offer(16'h0000);
    chk("ill_pulse", {15'd0, illegal}, 16'd1);
    chk("ill_no_wb", {15'd0, wbValid}, 16'd0);
    tick();
    chk("ill_ready_t2", {15'd0, instReady}, 16'd1);
    chk("ill_pulse_end", {15'd0, illegal}, 16'd0);
    chk("ill_nzp_kept", {13'd0, nzp}, 16'h0004);
    chk("ill_wbdata_hold", wbData, 16'hFFFA);
    chk("ill_wbreg_hold", {13'd0, wbReg}, 16'd5);
    rd(3'd0, "ill_r0_kept", 16'h0008);

    // Reset during EXEC of an ADD.
    offer(16'h1042);
    tick();
    chk("mid_exec_ctl", {14'd0, aluControl}, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {14'd0, aluControl}, 16'd0);
    chk("mid_rst_ra", aluRa, 16'd0);
    chk("mid_rst_nzp", {13'd0, nzp}, 16'h0002);
    chk("mid_rst_wbdata", wbData, 16'd0);
    rd(3'd1, "mid_rst_r1", 16'd0);
    tick();
    chk("mid_rst_no_wb", {15'd0, wbValid}, 16'd0);
    reset_n = 1'b1;
    tick();
    chk("mid_rst_ready", {15'd0, instReady}, 16'd1);
    run_op("add_zero", 16'h1042, 2'b01, 6'h02, 3'd0, 16'h0000, 3'b010);

    // Preload and offer in the same IDLE cycle: the preload wins.
    regWe = 1'b1; regAddr = 3'd1; regWData = 16'd7;
    instValid = 1'b1; instr = 16'h1042;
    #1;
    chk("coll_notready", {15'd0, instReady}, 16'd0);
    tick();
    regWe = 1'b0;
    #1;
    chk("coll_ready_next", {15'd0, instReady}, 16'd1);
    rd(3'd1, "coll_r1", 16'd7);
    tick();
    instValid = 1'b0;
    chk("coll_accepted", {15'd0, instReady}, 16'd0);
    tick();
    chk("coll_exec_ctl", {14'd0, aluControl}, 16'h0001);
    tick();
    chk("coll_wb_valid", {15'd0, wbValid}, 16'd1);
    chk("coll_wb_data", wbData, 16'd7);
    tick();
    chk("coll_nzp", {13'd0, nzp}, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
